uart_rx_cfg: RTL and testbench

//   Parametrised UART receiver; next generation of the fixed 8N1 x16 receiver.

---
 rtl/uart_rx_cfg.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver. It takes the shared baud*OVERSAMPLE tick and
//   the raw serial line, and delivers each received word through a
//   valid/ready holding register. The holding register reports parity and
//   framing errors, and an overrun pulse when a completed frame has to be
//   dropped.
//
//   Optional feature macro: UART_RX_MAJORITY_EN
//     defined   : each bit is the 2-of-3 majority of samples taken at MID-1,
//                 MID and MID+1. Every decision (bit value, start glitch
//                 check, frame completion) is taken at MID+1.
//     undefined : each bit is a single sample taken at MID.
//
// Parameters
//   DATA_BITS    data bits per frame, 5..9, LSB first
//   OVERSAMPLE   ticks per bit, even, 8..32
//   PARITY_MODE  0 none, 1 even, 2 odd
//   STOP_BITS    stop bits checked, 1 or 2
//
// Ports
//   clk          in   system clock
//   arst_n       in   synchronous active-low reset
//   tick         in   1-cycle strobe at baud*OVERSAMPLE
//   rx           in   asynchronous serial line, idle high
//   rx_data      out  received word, right-aligned, stable while rx_valid=1
//   rx_valid     out  word available in the holding register
//   rx_ready     in   consumer accepts the word when rx_valid && rx_ready
//   parity_err   out  parity mismatch for the held word
//   frame_err    out  a checked stop bit was sampled low for the held word
//   overrun_err  out  1-cycle pulse: completed frame dropped, holding reg full
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0] C_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] C_MID_M1 = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0] C_LAST   = OS_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // Decision point is the third of the three samples.
    localparam logic [OS_W-1:0] C_DEC    = OS_W'(OVERSAMPLE / 2);
`else
    localparam logic [OS_W-1:0] C_DEC    = C_MID;
`endif
    localparam logic [BC_W-1:0] C_LAST_BIT  = BC_W'(DATA_BITS - 1);
    localparam logic            C_LAST_STOP = (STOP_BITS == 2);
    localparam logic            C_ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [OS_W-1:0]       r_os_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic                  r_stop_cnt;
    logic [DATA_BITS-1:0]  r_shreg;
    logic                  r_par_int;
    logic                  r_frm_int;
    logic                  r_done;

    logic w_counting;
    logic w_dec;
    logic w_wrap;
    logic w_bit;

    // The oversample counter only runs while a frame is in progress.
    assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_dec      = tick && (r_os_cnt == C_DEC);
    assign w_wrap     = tick && (r_os_cnt == C_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic r_maj_a;
    logic r_maj_b;

    // Early samples at MID-1 and MID; the third sample is the live rx_s
    // at the decision tick.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else if (tick && w_counting) begin
            if (r_os_cnt == C_MID_M1) begin
                r_maj_a <= r_rx_s;
            end
            if (r_os_cnt == C_MID) begin
                r_maj_b <= r_rx_s;
            end
        end
    end

    assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_s) | (r_maj_b & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shreg    <= '0;
            r_par_int  <= 1'b0;
            r_frm_int  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_counting && tick) begin
                r_os_cnt <= (r_os_cnt == C_LAST) ? '0 : r_os_cnt + OS_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    // A tick coinciding with the falling edge is not counted.
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_os_cnt  <= '0;
                        r_par_int <= 1'b0;
                        r_frm_int <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_dec && w_bit) begin
                        // Line back high at mid start bit: a glitch.
                        r_state  <= S_IDLE;
                        r_os_cnt <= '0;
                    end else if (w_wrap) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end

                S_DATA: begin
                    // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                    if (w_dec) begin
                        r_shreg <= {w_bit, r_shreg[DATA_BITS-1:1]};
                    end
                    if (w_wrap) begin
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
                            r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    if (w_dec) begin
                        r_par_int <= (^{r_shreg, w_bit}) ^ C_ODD;
                    end
                    if (w_wrap) begin
                        r_state    <= S_STOP;
                        r_stop_cnt <= 1'b0;
                    end
                end

                S_STOP: begin
                    if (w_dec) begin
                        r_frm_int <= r_frm_int | ~w_bit;
                        // The frame completes mid last stop bit, so a
                        // back-to-back start edge is never missed.
                        if (r_stop_cnt == C_LAST_STOP) begin
                            r_done   <= 1'b1;
                            r_os_cnt <= '0;
                            r_state  <= (r_frm_int | ~w_bit) ? S_BREAK : S_IDLE;
                        end
                    end
                    if (w_wrap) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    // Hold off until the line is released so a stuck-low
                    // line is not read as a stream of start bits.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Valid/ready holding register
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_overrun_err <= 1'b0;
            if (r_done) begin
                // A simultaneous accept frees the register for the new word.
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shreg;
                    r_parity_err <= r_par_int;
                    r_frame_err  <= r_frm_int;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun_err <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Two receivers share clock, tick and reset:
//     dut_a : 8N1, OVERSAMPLE 16
//     dut_b : 8 data, even parity, 2 stop bits, OVERSAMPLE 8
//   Frames are built bit by bit from their serial description; expected
//   words and flags come from the frame contents (popcount parity, stop bit
//   levels). Accepted words are collected by a monitor into queues.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

    localparam int CLK_HALF = 5;
    localparam int TICK_DIV = 3;
    localparam int OS_A     = 16;
    localparam int OS_B     = 8;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       tick   = 1'b0;
    logic       rx_a   = 1'b1;
    logic       rx_b   = 1'b1;
    logic       rdy_a  = 1'b1;
    logic       rdy_b  = 1'b1;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    word_t got_a[$];
    word_t got_b[$];
    int    ovr_cnt_a = 0;
    int    ovr_cnt_b = 0;
    int    val_cyc_a = 0;

    uart_rx_cfg #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS_A),
        .PARITY_MODE(0),
        .STOP_BITS  (1)
    ) dut_a (
        .clk        (clk),
        .arst_n     (arst_n),
        .tick       (tick),
        .rx         (rx_a),
        .rx_data    (data_a),
        .rx_valid   (val_a),
        .rx_ready   (rdy_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .overrun_err(ovr_a)
    );

    uart_rx_cfg #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS_B),
        .PARITY_MODE(1),
        .STOP_BITS  (2)
    ) dut_b (
        .clk        (clk),
        .arst_n     (arst_n),
        .tick       (tick),
        .rx         (rx_b),
        .rx_data    (data_b),
        .rx_valid   (val_b),
        .rx_ready   (rdy_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .overrun_err(ovr_b)
    );

    always #CLK_HALF clk = ~clk;

    // Tick strobe: one cycle in every TICK_DIV, changed on the falling edge.
    int tick_div = 0;
    always @(negedge clk) begin
        tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        tick     = (tick_div == 0);
    end

    // Monitor: samples between the input update and the next rising edge.
    always @(negedge clk) begin
        #2;
        if (arst_n) begin
            if (val_a && rdy_a) begin
                got_a.push_back(word_t'({data_a, perr_a, ferr_a}));
                $display("[%0t] dut_a accepted data=%02h parity_err=%0b frame_err=%0b",
                         $time, data_a, perr_a, ferr_a);
            end
            if (val_b && rdy_b) begin
                got_b.push_back(word_t'({data_b, perr_b, ferr_b}));
                $display("[%0t] dut_b accepted data=%02h parity_err=%0b frame_err=%0b",
                         $time, data_b, perr_b, ferr_b);
            end
            if (ovr_a) ovr_cnt_a++;
            if (ovr_b) ovr_cnt_b++;
            if (val_a) val_cyc_a++;
        end
    end

    // Watchdog
    initial begin
        #3_000_000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(posedge clk);
            if (tick) seen++;
        end
    endtask

    task automatic drive_bit(input int inst, input logic b, input int nticks);
        @(negedge clk);
        if (inst == 0) rx_a = b;
        else           rx_b = b;
        wait_ticks(nticks);
    endtask

    // Leaves the line at the level of the last stop bit.
    task automatic send_frame(input int inst, input logic [7:0] d,
                              input logic pbit, input logic s1, input logic s2);
        int os;
        os = (inst == 0) ? OS_A : OS_B;
        drive_bit(inst, 1'b0, os);
        for (int i = 0; i < 8; i++) drive_bit(inst, d[i], os);
        if (inst == 1) drive_bit(inst, pbit, os);
        drive_bit(inst, s1, os);
        if (inst == 1) drive_bit(inst, s2, os);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        @(negedge clk);
        #2;
        n_vec++; if (val_a !== 1'b0)  begin n_miss++; $display("FAIL reset_valid_a: got %b required 0", val_a); end
        n_vec++; if (data_a !== 8'h00) begin n_miss++; $display("FAIL reset_data_a: got %02h required 00", data_a); end
        n_vec++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin n_miss++; $display("FAIL reset_flags_a: got %b required 000", {perr_a, ferr_a, ovr_a}); end
        n_vec++; if (val_b !== 1'b0)  begin n_miss++; $display("FAIL reset_valid_b: got %b required 0", val_b); end
        n_vec++; if (data_b !== 8'h00) begin n_miss++; $display("FAIL reset_data_b: got %02h required 00", data_b); end
        n_vec++; if ({perr_b, ferr_b, ovr_b} !== 3'b000) begin n_miss++; $display("FAIL reset_flags_b: got %b required 000", {perr_b, ferr_b, ovr_b}); end
        @(negedge clk);
        arst_n = 1'b1;
        wait_ticks(40);
        n_vec++; if (val_a !== 1'b0 || val_b !== 1'b0) begin n_miss++; $display("FAIL idle_valid: got %b%b required 00", val_a, val_b); end
    endtask

    task automatic test_basic;
        word_t w;
        rdy_a = 1'b1;
        val_cyc_a = 0;
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        // Completion is mid stop bit, so the word is already out here.
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL basic_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'hA5) begin n_miss++; $display("FAIL basic_data: got %02h required a5", w.d); end
            n_vec++; if ({w.pe, w.fe} !== 2'b00) begin n_miss++; $display("FAIL basic_flags: got %b required 00", {w.pe, w.fe}); end
        end
        wait_ticks(4);
        n_vec++; if (val_cyc_a != 1) begin n_miss++; $display("FAIL basic_valid_len: got %0d cycles required 1", val_cyc_a); end
        got_a.delete();
    endtask

    task automatic test_random;
        logic [7:0] d;
        word_t w;
        rdy_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            send_frame(0, d, 1'b0, 1'b1, 1'b1);
            n_vec++;
            if (got_a.size() != 1) begin
                n_miss++; $display("FAIL random_count: frame %0d got %0d words required 1", k, got_a.size());
                got_a.delete();
            end else begin
                w = got_a.pop_front();
                n_vec++; if (w.d !== d || {w.pe, w.fe} !== 2'b00) begin
                    n_miss++; $display("FAIL random_word: got %02h/%b required %02h/00", w.d, {w.pe, w.fe}, d);
                end
            end
        end
    endtask

    task automatic test_parity;
        logic [7:0] d;
        logic       pb, s1, s2, exp_pe, exp_fe;
        word_t      w;
        rdy_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      begin d = 8'h3C; pb = 1'b1; s1 = 1'b1; s2 = 1'b1; end
            else if (k == 1) begin d = 8'h3C; pb = 1'b0; s1 = 1'b1; s2 = 1'b1; end
            else begin
                d  = 8'($urandom);
                pb = 1'($urandom);
                s1 = ($urandom_range(0, 3) != 0);
                s2 = ($urandom_range(0, 3) != 0);
            end
            // Even parity: total count of ones over data and parity bit is even.
            exp_pe = ((($countones(d) + int'(pb)) % 2) != 0);
            exp_fe = !(s1 && s2);
            send_frame(1, d, pb, s1, s2);
            n_vec++;
            if (got_b.size() != 1) begin
                n_miss++; $display("FAIL parity_count: frame %0d got %0d words required 1", k, got_b.size());
                got_b.delete();
            end else begin
                w = got_b.pop_front();
                n_vec++; if (w.d !== d) begin n_miss++; $display("FAIL parity_data: got %02h required %02h", w.d, d); end
                n_vec++; if (w.pe !== exp_pe) begin n_miss++; $display("FAIL parity_err: data %02h pbit %b got %b required %b", d, pb, w.pe, exp_pe); end
                n_vec++; if (w.fe !== exp_fe) begin n_miss++; $display("FAIL parity_frame_err: stops %b%b got %b required %b", s1, s2, w.fe, exp_fe); end
            end
            drive_bit(1, 1'b1, 2 * OS_B);
        end
    endtask

    task automatic test_glitch;
        word_t w;
        rdy_a = 1'b1;
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 3 * OS_A);
        n_vec++; if (got_a.size() != 0 || val_a !== 1'b0) begin
            n_miss++; $display("FAIL glitch_no_word: got %0d words valid %b required 0 words valid 0", got_a.size(), val_a);
        end
        got_a.delete();
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL glitch_next_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'h55 || {w.pe, w.fe} !== 2'b00) begin
                n_miss++; $display("FAIL glitch_next_word: got %02h/%b required 55/00", w.d, {w.pe, w.fe});
            end
        end
        got_a.delete();
    endtask

    task automatic test_break;
        word_t w;
        rdy_a = 1'b1;
        // Stop bit low; the line then stays low for 40 ticks in total.
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL break_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'h81) begin n_miss++; $display("FAIL break_data: got %02h required 81", w.d); end
            n_vec++; if (w.fe !== 1'b1) begin n_miss++; $display("FAIL break_frame_err: got %b required 1", w.fe); end
        end
        got_a.delete();
        wait_ticks(40 - OS_A);
        drive_bit(0, 1'b1, OS_A);
        n_vec++; if (got_a.size() != 0) begin
            n_miss++; $display("FAIL break_hold: got %0d words while line low required 0", got_a.size());
        end
        got_a.delete();
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL break_next_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'h12 || w.fe !== 1'b0) begin
                n_miss++; $display("FAIL break_next_word: got %02h fe %b required 12 fe 0", w.d, w.fe);
            end
        end
        got_a.delete();
    endtask

    task automatic test_overrun;
        word_t w;
        @(negedge clk);
        rdy_a = 1'b0;
        ovr_cnt_a = 0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        wait_ticks(OS_A);
        #2;
        n_vec++; if (val_a !== 1'b1) begin n_miss++; $display("FAIL overrun_valid: got %b required 1", val_a); end
        n_vec++; if (data_a !== 8'h11) begin n_miss++; $display("FAIL overrun_data: got %02h required 11", data_a); end
        n_vec++; if (ovr_cnt_a != 1) begin n_miss++; $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt_a); end
        @(negedge clk);
        rdy_a = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL overrun_drain_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'h11) begin n_miss++; $display("FAIL overrun_drain_data: got %02h required 11", w.d); end
        end
        n_vec++; if (val_a !== 1'b0) begin n_miss++; $display("FAIL overrun_drain_valid: got %b required 0", val_a); end
        got_a.delete();
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        word_t      w;
        @(negedge clk);
        rdy_a = 1'b0;
        ovr_cnt_a = 0;
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        wait_ticks(OS_A);
        #2;
        n_vec++; if (val_a !== 1'b1 || data_a !== 8'h5A) begin
            n_miss++; $display("FAIL rst_pre_hold: got valid %b data %02h required 1/5a", val_a, data_a);
        end
        // Start a frame and reset in the middle of data bit 4.
        d = 8'hC3;
        drive_bit(0, 1'b0, OS_A);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], OS_A);
        drive_bit(0, d[4], OS_A / 2);
        @(negedge clk);
        arst_n = 1'b0;
        rx_a   = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        #2;
        n_vec++; if (val_a !== 1'b0) begin n_miss++; $display("FAIL rst_mid_valid: got %b required 0", val_a); end
        n_vec++; if (data_a !== 8'h00) begin n_miss++; $display("FAIL rst_mid_data: got %02h required 00", data_a); end
        n_vec++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin n_miss++; $display("FAIL rst_mid_flags: got %b required 000", {perr_a, ferr_a, ovr_a}); end
        wait_ticks(3 * OS_A);
        #2;
        n_vec++; if (val_a !== 1'b0 || ovr_cnt_a != 0 || got_a.size() != 0) begin
            n_miss++; $display("FAIL rst_mid_abort: got valid %b overruns %0d words %0d required 0/0/0", val_a, ovr_cnt_a, got_a.size());
        end
        got_a.delete();
        @(negedge clk);
        rdy_a = 1'b1;
        send_frame(0, 8'hF0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (got_a.size() != 1) begin
            n_miss++; $display("FAIL rst_next_count: got %0d words required 1", got_a.size());
        end else begin
            w = got_a.pop_front();
            n_vec++; if (w.d !== 8'hF0 || {w.pe, w.fe} !== 2'b00) begin
                n_miss++; $display("FAIL rst_next_word: got %02h/%b required f0/00", w.d, {w.pe, w.fe});
            end
        end
        got_a.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_random;
        test_parity;
        test_glitch;
        test_break;
        test_overrun;
        test_reset_midframe;
        wait_ticks(8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
